// File: rtl/ads5296_align_pkg.sv
// Shared types and sizing helpers for the ADS5296 frame-alignment gearbox.
package ads5296_align_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

    function automatic int lvl_bits(input int frame_bits, input int beat_bits);
        return $clog2(frame_bits + beat_bits + 1);
    endfunction

endpackage

// File: rtl/ads5296_gearbox.sv
// W-bit to F-bit bit-slip gearbox for one lane; fill level and strobes come from the aligner.
module ads5296_gearbox
    import ads5296_align_pkg::*;
#(
    parameter int G_BEAT_BITS  = 4,
    parameter int G_FRAME_BITS = 10,
    parameter int G_LVL_BITS   = lvl_bits(G_FRAME_BITS, G_BEAT_BITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [G_BEAT_BITS-1:0]  beat,
    input  logic [G_LVL_BITS-1:0]   lvl,
    input  logic                    slip,
    input  logic                    extract,
    output logic [G_FRAME_BITS-1:0] word
);

    localparam int BUF_W = G_FRAME_BITS + G_BEAT_BITS;

    // bit 0 is the oldest buffered bit; bits at or above lvl are always zero
    logic [BUF_W-1:0]        bits_q;
    logic [BUF_W-1:0]        merged;
    logic [BUF_W-1:0]        shifted;
    logic [G_FRAME_BITS-1:0] word_next;

    always_comb begin
        merged    = bits_q | (BUF_W'(beat) << lvl);
        word_next = '0;
        for (int unsigned k = 0; k < G_FRAME_BITS; k++) begin
            word_next[G_FRAME_BITS-1-k] = merged[k];
        end
        if (slip) begin
            shifted = merged >> 1;
        end else if (extract) begin
            shifted = merged >> G_FRAME_BITS;
        end else begin
            shifted = merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bits_q <= '0;
            word   <= '0;
        end else begin
            bits_q <= shifted;
            if (extract && !slip) begin
                word <= word_next;
            end
        end
    end

endmodule

// File: rtl/ads5296_frame_align.sv
// ADS5296 frame aligner: bit-slips all lanes until the fclk word matches, then tracks lock.
module ads5296_frame_align
    import ads5296_align_pkg::*;
#(
    parameter int                      G_NUM_LANES    = 8,
    parameter int                      G_BEAT_BITS    = 4,
    parameter int                      G_FRAME_BITS   = 10,
    parameter logic [G_FRAME_BITS-1:0] G_FCLK_PATTERN = 10'b1111100000,
    parameter int                      G_LOCK_CNT     = 16,
    parameter int                      G_UNLOCK_ERRS  = 4,
    parameter int                      G_SLIP_WAIT    = 2
) (
    input  logic                                lclk_d4,
    input  logic                                rst,
    input  logic [G_BEAT_BITS-1:0]              fclk_beat,
    input  logic [G_BEAT_BITS*G_NUM_LANES-1:0]  din_beat,
    input  logic                                realign,
    output logic [G_FRAME_BITS*G_NUM_LANES-1:0] dout,
    output logic                                dout_vld,
    output logic [G_FRAME_BITS-1:0]             fclk_word,
    output logic                                locked,
    output logic                                search_fail,
    output logic [7:0]                          slip_cnt,
    output logic [31:0]                         err_cnt
);

    localparam int LW     = lvl_bits(G_FRAME_BITS, G_BEAT_BITS);
    localparam int WAIT_W = $clog2(G_SLIP_WAIT + 2);
    localparam int GOOD_W = $clog2(G_LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(G_UNLOCK_ERRS + 1);
    localparam logic [7:0] SEARCH_LIMIT = 8'(2 * G_FRAME_BITS);

    align_state_t      state_q, state_d;
    logic [LW-1:0]     lvl_q, lvl_d, lvl_post;
    logic              slip, extract, word_new, match;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [BAD_W-1:0]  bad_q, bad_d;
    logic [7:0]        slip_cnt_d, slip_inc;
    logic [31:0]       err_cnt_d, err_inc;
    logic              search_fail_d;

    assign lvl_post = lvl_q + LW'(G_BEAT_BITS);
    assign extract  = !slip && (lvl_post >= LW'(G_FRAME_BITS));
    assign match    = (fclk_word == G_FCLK_PATTERN);
    assign slip_inc = (slip_cnt == '1) ? slip_cnt : slip_cnt + 8'd1;
    assign err_inc  = (err_cnt == '1) ? err_cnt : err_cnt + 32'd1;
    assign locked   = (state_q == LOCKED);
    assign dout_vld = word_new && locked;

    always_comb begin
        if (slip) begin
            lvl_d = lvl_post - LW'(1);
        end else if (extract) begin
            lvl_d = lvl_post - LW'(G_FRAME_BITS);
        end else begin
            lvl_d = lvl_post;
        end
    end

    // Decisions use the registered word, so a slip always lands the cycle after an extraction.
    always_comb begin
        state_d       = state_q;
        slip          = 1'b0;
        wait_d        = wait_q;
        good_d        = good_q;
        bad_d         = bad_q;
        slip_cnt_d    = slip_cnt;
        err_cnt_d     = err_cnt;
        search_fail_d = search_fail;
        if (realign) begin
            state_d       = SEARCH;
            wait_d        = '0;
            good_d        = '0;
            bad_d         = '0;
            slip_cnt_d    = '0;
            err_cnt_d     = '0;
            search_fail_d = 1'b0;
        end else if (word_new) begin
            case (state_q)
                SEARCH: begin
                    if (wait_q != '0) begin
                        wait_d = wait_q - WAIT_W'(1);
                    end else if (match) begin
                        state_d = CHECK;
                        good_d  = GOOD_W'(1);
                    end else begin
                        slip       = 1'b1;
                        slip_cnt_d = slip_inc;
                        wait_d     = WAIT_W'(G_SLIP_WAIT);
                        if (slip_inc >= SEARCH_LIMIT) search_fail_d = 1'b1;
                    end
                end
                CHECK: begin
                    if (match) begin
                        good_d = good_q + GOOD_W'(1);
                        if (good_d >= GOOD_W'(G_LOCK_CNT)) state_d = LOCKED;
                    end else begin
                        state_d    = SEARCH;
                        slip       = 1'b1;
                        slip_cnt_d = slip_inc;
                        wait_d     = WAIT_W'(G_SLIP_WAIT);
                        good_d     = '0;
                        if (slip_inc >= SEARCH_LIMIT) search_fail_d = 1'b1;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        bad_d = '0;
                    end else begin
                        err_cnt_d = err_inc;
                        bad_d     = bad_q + BAD_W'(1);
                        if (bad_d >= BAD_W'(G_UNLOCK_ERRS)) begin
                            state_d    = SEARCH;
                            bad_d      = '0;
                            good_d     = '0;
                            wait_d     = '0;
                            slip_cnt_d = '0;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge lclk_d4) begin
        if (rst) begin
            state_q     <= SEARCH;
            lvl_q       <= '0;
            word_new    <= 1'b0;
            wait_q      <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            slip_cnt    <= '0;
            err_cnt     <= '0;
            search_fail <= 1'b0;
        end else begin
            state_q     <= state_d;
            lvl_q       <= lvl_d;
            word_new    <= extract;
            wait_q      <= wait_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            slip_cnt    <= slip_cnt_d;
            err_cnt     <= err_cnt_d;
            search_fail <= search_fail_d;
        end
    end

    ads5296_gearbox #(
        .G_BEAT_BITS  (G_BEAT_BITS),
        .G_FRAME_BITS (G_FRAME_BITS),
        .G_LVL_BITS   (LW)
    ) u_fclk_gb (
        .clk     (lclk_d4),
        .rst     (rst),
        .beat    (fclk_beat),
        .lvl     (lvl_q),
        .slip    (slip),
        .extract (extract),
        .word    (fclk_word)
    );

    for (genvar g = 0; g < G_NUM_LANES; g++) begin : g_lane
        ads5296_gearbox #(
            .G_BEAT_BITS  (G_BEAT_BITS),
            .G_FRAME_BITS (G_FRAME_BITS),
            .G_LVL_BITS   (LW)
        ) u_lane_gb (
            .clk     (lclk_d4),
            .rst     (rst),
            .beat    (din_beat[g*G_BEAT_BITS +: G_BEAT_BITS]),
            .lvl     (lvl_q),
            .slip    (slip),
            .extract (extract),
            .word    (dout[g*G_FRAME_BITS +: G_FRAME_BITS])
        );
    end

endmodule
